// File: rtl/nmt_host_port_if.sv
// rtl/nmt_host_port_if.sv - host request, thread claim/release and NMT device bus bundle
interface nmt_host_port_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              req_write;
    logic              claim_valid;
    logic [ADDR_W-1:0] claim_addr;
    logic              release_valid;
    logic [ADDR_W-1:0] release_addr;
    logic [ADDR_W-1:0] used_address;
    logic              read_or_write;
    logic              host_active;
    logic [ADDR_W-1:0] released_address;
    logic              freed;
    logic              context_switch;
    logic              table_full;
    logic              overflow;

    modport master (
        output req_valid, req_addr, req_write,
        output claim_valid, claim_addr, release_valid, release_addr,
        input  req_ready, used_address, read_or_write, host_active,
        input  released_address, freed, context_switch, table_full, overflow
    );

    modport slave (
        input  req_valid, req_addr, req_write,
        input  claim_valid, claim_addr, release_valid, release_addr,
        output req_ready, used_address, read_or_write, host_active,
        output released_address, freed, context_switch, table_full, overflow
    );
endinterface

// File: rtl/nmt_host_port.sv
// rtl/nmt_host_port.sv - host initiator into the NMT device with thread-claim table and collision context switch
module nmt_host_port #(
    parameter int ADDR_W        = 9,
    parameter int DEPTH         = 8,
    parameter int HOLD_CYCLES   = 4,
    parameter int SWITCH_CYCLES = 2
) (
    input logic            clk,
    input logic            rst_n,
    nmt_host_port_if.slave bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > SWITCH_CYCLES) ? HOLD_CYCLES : SWITCH_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CHECK, SWITCH, ACCESS, RELEASE} state_t;

    state_t                       state_q;
    logic [CNT_W-1:0]             cnt_q;
    logic [ADDR_W-1:0]            cap_addr_q;
    logic                         cap_wr_q;
    logic                         req_ready_q;
    logic                         host_active_q;
    logic [ADDR_W-1:0]            used_address_q;
    logic                         read_or_write_q;
    logic [ADDR_W-1:0]            released_address_q;
    logic                         freed_q;
    logic                         context_switch_q;
    logic                         table_full_q;
    logic                         overflow_q;

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][ADDR_W-1:0] tab_addr_q, tab_addr_d;
    logic                         ovf_set;
    logic                         present;
    logic                         placed;
    logic                         hit;

    // Release is applied first so a full table can reuse the freed slot in the same cycle.
    always_comb begin
        valid_d    = valid_q;
        tab_addr_d = tab_addr_q;
        ovf_set    = 1'b0;
        present    = 1'b0;
        placed     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.release_valid && valid_q[i] && tab_addr_q[i] == bus.release_addr)
                valid_d[i] = 1'b0;
            if (valid_q[i] && tab_addr_q[i] == bus.claim_addr)
                present = 1'b1;
        end
        if (bus.claim_valid && !present &&
            !(bus.release_valid && bus.release_addr == bus.claim_addr)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!placed && !valid_d[i]) begin
                    valid_d[i]    = 1'b1;
                    tab_addr_d[i] = bus.claim_addr;
                    placed        = 1'b1;
                end
            end
            ovf_set = !placed;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid_q[i] && tab_addr_q[i] == cap_addr_q)
                hit = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            tab_addr_q   <= '0;
            table_full_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            tab_addr_q   <= tab_addr_d;
            table_full_q <= &valid_d;
            overflow_q   <= overflow_q | ovf_set;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            cap_addr_q         <= '0;
            cap_wr_q           <= 1'b0;
            req_ready_q        <= 1'b0;
            host_active_q      <= 1'b0;
            used_address_q     <= '0;
            read_or_write_q    <= 1'b0;
            released_address_q <= '0;
            freed_q            <= 1'b0;
            context_switch_q   <= 1'b0;
        end else begin
            freed_q          <= 1'b0;
            context_switch_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_ready_q && bus.req_valid) begin
                        cap_addr_q  <= bus.req_addr;
                        cap_wr_q    <= bus.req_write;
                        req_ready_q <= 1'b0;
                        state_q     <= CHECK;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                CHECK: begin
                    if (hit) begin
                        context_switch_q <= 1'b1;
                        cnt_q            <= CNT_W'(SWITCH_CYCLES - 1);
                        state_q          <= SWITCH;
                    end else begin
                        host_active_q   <= 1'b1;
                        used_address_q  <= cap_addr_q;
                        read_or_write_q <= cap_wr_q;
                        cnt_q           <= CNT_W'(HOLD_CYCLES - 1);
                        state_q         <= ACCESS;
                    end
                end
                // The parked thread's release does not matter here; the wait always runs to completion.
                SWITCH: begin
                    if (cnt_q == '0) begin
                        host_active_q   <= 1'b1;
                        used_address_q  <= cap_addr_q;
                        read_or_write_q <= cap_wr_q;
                        cnt_q           <= CNT_W'(HOLD_CYCLES - 1);
                        state_q         <= ACCESS;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt_q == '0) begin
                        host_active_q      <= 1'b0;
                        used_address_q     <= '0;
                        read_or_write_q    <= 1'b0;
                        freed_q            <= 1'b1;
                        released_address_q <= cap_addr_q;
                        state_q            <= RELEASE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RELEASE: begin
                    req_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready        = req_ready_q;
    assign bus.host_active      = host_active_q;
    assign bus.used_address     = used_address_q;
    assign bus.read_or_write    = read_or_write_q;
    assign bus.released_address = released_address_q;
    assign bus.freed            = freed_q;
    assign bus.context_switch   = context_switch_q;
    assign bus.table_full       = table_full_q;
    assign bus.overflow         = overflow_q;
endmodule

// File: tb/tb_nmt_host_port.sv
// tb/tb_nmt_host_port.sv - self-checking bench for nmt_host_port against a timeline/set model
module tb_nmt_host_port;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 8;
    localparam int H      = 4;
    localparam int S      = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nmt_host_port_if #(.ADDR_W(ADDR_W)) bus ();

    nmt_host_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .HOLD_CYCLES(H), .SWITCH_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: claimed addresses as a set, host access as offsets from its acceptance cycle.
    bit              set_m[int];
    bit              up_m, busy_m, hit_m, ovf_m;
    int              d_m, s_m;
    logic [8:0]      a_m, last_rel_m;
    logic            w_m;
    bit              e_act, e_fr, e_cs, e_rdy;
    int              acc_cyc, cs_cnt, cs_off, fr_off, act_cnt, act_first;
    int              acc_list[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready",  32'(bus.req_ready), 0);
            chk("rst_host_active", 32'(bus.host_active), 0);
            chk("rst_used_address", 32'(bus.used_address), 0);
            chk("rst_read_or_write", 32'(bus.read_or_write), 0);
            chk("rst_freed", 32'(bus.freed), 0);
            chk("rst_released_address", 32'(bus.released_address), 0);
            chk("rst_context_switch", 32'(bus.context_switch), 0);
            chk("rst_table_full", 32'(bus.table_full), 0);
            chk("rst_overflow", 32'(bus.overflow), 0);
            set_m.delete();
            up_m = 0; busy_m = 0; hit_m = 0; ovf_m = 0; d_m = 0;
            last_rel_m = '0; fr_off = -1; cs_cnt = 0; act_cnt = 0;
        end else begin
            s_m   = hit_m ? S : 0;
            e_rdy = up_m && !busy_m;
            e_act = busy_m && d_m >= 2 + s_m && d_m <= 1 + s_m + H;
            e_fr  = busy_m && d_m == 2 + s_m + H;
            e_cs  = busy_m && hit_m && d_m == 2;
            chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
            chk("host_active", 32'(bus.host_active), 32'(e_act));
            chk("used_address", 32'(bus.used_address), e_act ? 32'(a_m) : 0);
            chk("read_or_write", 32'(bus.read_or_write), e_act ? 32'(w_m) : 0);
            chk("freed", 32'(bus.freed), 32'(e_fr));
            chk("released_address", 32'(bus.released_address), e_fr ? 32'(a_m) : 32'(last_rel_m));
            chk("context_switch", 32'(bus.context_switch), 32'(e_cs));
            chk("table_full", 32'(bus.table_full), 32'(set_m.num() == DEPTH));
            chk("overflow", 32'(bus.overflow), 32'(ovf_m));

            if (bus.context_switch) begin cs_cnt++; cs_off = cyc - acc_cyc; end
            if (bus.host_active) begin
                act_cnt++;
                if (act_first < 0) act_first = cyc - acc_cyc;
            end
            if (bus.freed) fr_off = cyc - acc_cyc;

            if (busy_m) begin
                if (d_m == 1) hit_m = set_m.exists(int'(a_m));
                if (d_m == 2 + (hit_m ? S : 0) + H) last_rel_m = a_m;
                d_m++;
                if (d_m == 3 + H + (hit_m ? S : 0)) busy_m = 0;
            end else if (up_m && bus.req_valid) begin
                busy_m = 1; d_m = 1; hit_m = 0;
                a_m = bus.req_addr; w_m = bus.req_write;
                acc_cyc = cyc; cs_cnt = 0; cs_off = -1; fr_off = -1;
                act_cnt = 0; act_first = -1;
                acc_list.push_back(cyc);
            end
            if (bus.release_valid) set_m.delete(int'(bus.release_addr));
            if (bus.claim_valid && !(bus.release_valid && bus.release_addr == bus.claim_addr)
                && !set_m.exists(int'(bus.claim_addr))) begin
                if (set_m.num() < DEPTH) set_m[int'(bus.claim_addr)] = 1;
                else ovf_m = 1;
            end
            up_m = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req_valid = 0; bus.claim_valid = 0; bus.release_valid = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 50) begin tick(); n++; end
        if (n >= 50) chk("req_ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [8:0] a, input logic w);
        wait_ready();
        bus.req_valid = 1; bus.req_addr = a; bus.req_write = w;
        tick();
        bus.req_valid = 0;
    endtask

    task automatic claim(input logic [8:0] a);
        bus.claim_valid = 1; bus.claim_addr = a;
        tick();
        bus.claim_valid = 0;
    endtask

    task automatic release_a(input logic [8:0] a);
        bus.release_valid = 1; bus.release_addr = a;
        tick();
        bus.release_valid = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 0; bus.req_addr = '0; bus.req_write = 0;
        bus.claim_valid = 0; bus.claim_addr = '0;
        bus.release_valid = 0; bus.release_addr = '0;
        do_reset();
        chk("lit_ready_after_reset", 32'(bus.req_ready), 1);

        send(9'h055, 1'b1);
        repeat (10) tick();
        chk("lit_wr_freed_off", fr_off, 6);
        chk("lit_wr_act_first", act_first, 2);
        chk("lit_wr_act_cnt", act_cnt, 4);
        chk("lit_wr_cs_cnt", cs_cnt, 0);
        chk("lit_wr_released", 32'(bus.released_address), 32'h055);

        claim(9'h120);
        send(9'h120, 1'b0);
        tick();
        release_a(9'h120);
        repeat (10) tick();
        chk("lit_col_cs_cnt", cs_cnt, 1);
        chk("lit_col_cs_off", cs_off, 2);
        chk("lit_col_act_first", act_first, 4);
        chk("lit_col_act_cnt", act_cnt, 4);
        chk("lit_col_freed_off", fr_off, 8);

        bus.claim_valid = 1; bus.claim_addr = 9'h0AA;
        bus.release_valid = 1; bus.release_addr = 9'h0AA;
        tick();
        bus.claim_valid = 0; bus.release_valid = 0;
        send(9'h0AA, 1'b1);
        repeat (10) tick();
        chk("lit_simul_cs_cnt", cs_cnt, 0);

        claim(9'h0AA);
        claim(9'h0AA);
        for (int i = 0; i < 6; i++) claim(9'h100 + 9'(i));
        chk("lit_dup_not_full", 32'(bus.table_full), 0);
        claim(9'h1F0);
        chk("lit_dup_full", 32'(bus.table_full), 1);
        chk("lit_dup_no_ovf", 32'(bus.overflow), 0);
        send(9'h0AA, 1'b0);
        repeat (10) tick();
        chk("lit_dup_cs_cnt", cs_cnt, 1);

        do_reset();
        for (int i = 0; i < 8; i++) claim(9'h010 + 9'(i));
        chk("lit_ovf_full", 32'(bus.table_full), 1);
        chk("lit_ovf_pre", 32'(bus.overflow), 0);
        claim(9'h018);
        chk("lit_ovf_set", 32'(bus.overflow), 1);
        send(9'h018, 1'b1);
        repeat (10) tick();
        chk("lit_ovf_dropped_cs", cs_cnt, 0);
        bus.release_valid = 1; bus.release_addr = 9'h010;
        bus.claim_valid = 1; bus.claim_addr = 9'h018;
        tick();
        bus.release_valid = 0; bus.claim_valid = 0;
        chk("lit_swap_full", 32'(bus.table_full), 1);
        send(9'h018, 1'b0);
        repeat (10) tick();
        chk("lit_swap_cs_cnt", cs_cnt, 1);
        chk("lit_ovf_sticky", 32'(bus.overflow), 1);

        do_reset();
        chk("lit_ovf_cleared", 32'(bus.overflow), 0);
        wait_ready();
        acc_list.delete();
        bus.req_valid = 1; bus.req_addr = 9'h033; bus.req_write = 0;
        repeat (25) tick();
        bus.req_valid = 0;
        repeat (10) tick();
        chk("lit_b2b_count", acc_list.size(), 4);
        for (int i = 1; i < acc_list.size(); i++)
            chk("lit_b2b_spacing", acc_list[i] - acc_list[i-1], H + 3);

        send(9'h1AB, 1'b1);
        repeat (3) tick();
        chk("lit_abort_pre_active", 32'(bus.host_active), 1);
        rst_n = 1'b0;
        #1;
        chk("lit_abort_active", 32'(bus.host_active), 0);
        chk("lit_abort_used", 32'(bus.used_address), 0);
        chk("lit_abort_rw", 32'(bus.read_or_write), 0);
        chk("lit_abort_ready", 32'(bus.req_ready), 0);
        chk("lit_abort_released", 32'(bus.released_address), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("lit_abort_ready_after", 32'(bus.req_ready), 1);
        chk("lit_abort_table_empty", 32'(bus.table_full), 0);
        repeat (10) tick();
        chk("lit_abort_no_freed", fr_off, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nmt_host_port.md
# nmt_host_port

Host-side initiator for the near-memory-thread (NMT) device's memory interface. It accepts host read/write requests and drives `used_address`, `read_or_write`, `released_address` and `freed` into the NMT device. It tracks the addresses currently claimed by NMT threads. On a host/thread address collision it raises `context_switch` so the NMT pipeline parks its thread before the host access proceeds. It sits between the host request source and the NMT device's controller inputs.

## Interface
- `ADDR_W`, 9: address width; matches the NMT controller address bus.
- `DEPTH`, 8: entries in the thread-claim table.
- `HOLD_CYCLES`, 4: cycles `used_address` is held per host access (≥1).
- `SWITCH_CYCLES`, 2: wait cycles after a context-switch pulse before the access starts (≥1).

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: host request valid.
- `req_ready` output 1: port can accept a request.
- `req_addr` input ADDR_W: host request address.
- `req_write` input 1: 1 = write, 0 = read.
- `claim_valid` input 1: an NMT thread claims `claim_addr`.
- `claim_addr` input ADDR_W: address being claimed.
- `release_valid` input 1: an NMT thread releases `release_addr`.
- `release_addr` input ADDR_W: address being released.
- `used_address` output ADDR_W: address of the host access in progress.
- `read_or_write` output 1: direction of the host access in progress.
- `host_active` output 1: `used_address`/`read_or_write` are valid.
- `released_address` output ADDR_W: address the host has just finished with.
- `freed` output 1: one-cycle pulse qualifying `released_address`.
- `context_switch` output 1: one-cycle collision pulse to the NMT pipeline.
- `table_full` output 1: all DEPTH entries valid.
- `overflow` output 1: sticky; set when a claim is dropped; cleared only by reset.

## Operation
- **FSM states:** IDLE, CHECK, SWITCH, ACCESS, RELEASE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, capture `req_addr` and `req_write`, then go to CHECK.
- **CHECK** (1 cycle)
  - Compare the captured address against all valid table entries, using the registered table contents.
  - Hit: go to SWITCH.
  - Miss: go to ACCESS.
- **SWITCH**
  - `context_switch`=1 in the first cycle only.
  - Remain in SWITCH for SWITCH_CYCLES cycles total, then go to ACCESS.
  - A release of the colliding address during SWITCH does not shorten or abort the state.
- **ACCESS**
  - `host_active`=1, `used_address`=captured address, `read_or_write`=captured direction, held for HOLD_CYCLES cycles.
  - Then go to RELEASE.
- **RELEASE** (1 cycle)
  - `freed`=1 and `released_address`=captured address.
  - Then go to IDLE.
- **Idle output values:** when not active, `used_address`=0 and `read_or_write`=0. `released_address` keeps its last value.
- **Claim table:** DEPTH entries of {valid, addr}; updated every cycle, independent of the FSM.
  - A claim of an address already present: no change, no duplicate.
  - A claim of a new address goes into the lowest-index free entry.
  - A claim while full (and not present) is dropped and sets `overflow`.
  - A release clears the matching entry. A release of an absent address has no effect.
  - Same cycle, same address, claim and release: release wins; the address ends absent.
  - Same cycle, different addresses: both are applied. If the table is full, the slot freed by the release is usable by the claim in that same cycle.
  - `table_full` is registered and reflects the post-update count.

## Timing
- **Reset:** all outputs 0, FSM in IDLE, table empty, `overflow`=0. Note `req_ready` is 0 during reset and 1 in the first cycle after deassertion.
- **Acceptance:** a request is accepted in cycle T when `req_valid` & `req_ready`.
- **No-collision path:**
  - CHECK at T+1.
  - `host_active` T+2 … T+1+HOLD_CYCLES.
  - `freed` at T+2+HOLD_CYCLES.
  - `req_ready` again at T+3+HOLD_CYCLES.
- **Collision path:**
  - `context_switch` at T+2.
  - ACCESS begins at T+2+SWITCH_CYCLES.
  - `freed` at T+2+SWITCH_CYCLES+HOLD_CYCLES.
- **Claim visibility:** a claim at cycle T+1 (the CHECK cycle) is not seen by that comparison. A claim at T or earlier is seen.
- **Outputs:** all registered; no combinational input-to-output path except none.
- **Reset mid-operation:** any state returns to IDLE immediately. No `freed` pulse is emitted for the aborted access.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-ACCESS → all outputs 0 asynchronously; after release `req_ready`=1 and the table is empty.
- **Plain write:** defaults, write to 0x055 with an empty table → `host_active` for 4 cycles with `used_address`=0x055 and `read_or_write`=1; `freed` pulse with `released_address`=0x055 at T+6; no `context_switch`.
- **Collision:** claim 0x120, then a read of 0x120 → `context_switch` for exactly 1 cycle at T+2; access T+4..T+7; `freed` at T+8.
- **Table overflow:** claim 8 distinct addresses then a 9th → `table_full`=1 and `overflow`=1; the 9th address does not collide. Release one, then claim the 9th → accepted.
- **Simultaneous claim/release:**
  - Claim and release 0x0AA in the same cycle → the address is absent; a subsequent request to 0x0AA gives no `context_switch`.
  - Duplicate claim of 0x0AA → occupies one entry only.
- **Back-to-back requests:** hold `req_valid` continuously → accepts spaced exactly HOLD_CYCLES+3 apart; `req_ready` is low outside IDLE.
